// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters and a saturating mispredict counter.
// Optional macro GSHARE_EN moves direction counters into a gshare pattern table indexed by pc index XOR global history.
module branch_predictor_btb #(
    parameter int         ENTRIES  = 16,
    parameter int         ADDR_W   = 32,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              flush,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       lookup_ctr;
    logic             unused_pc_bits;

    assign lookup_idx     = lookup_pc[IDX_W+1:2];
    assign lookup_tag     = lookup_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign upd_tag        = upd_pc[ADDR_W-1:IDX_W+2];
    assign upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads registered contents only, so a same-cycle update is never bypassed.
    always_comb begin
        pred_hit       = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        pred_taken     = pred_hit && lookup_ctr[1];
        pred_target    = pred_hit ? target_q[lookup_idx] : lookup_pc + ADDR_W'(4);
        mispredict_cnt = cnt_q;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
            end
        end
    end

    // Statistics keep counting through a flush; only reset clears them.
    always_comb begin
        cnt_d = cnt_q;
        if (upd_valid && upd_mispredict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef GSHARE_EN
    logic [1:0]       pht_q [ENTRIES];
    logic [1:0]       pht_d [ENTRIES];
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;
    logic [IDX_W-1:0] upd_pht_idx;

    assign upd_pht_idx = upd_idx ^ ghr_q;
    assign lookup_ctr  = pht_q[lookup_idx ^ ghr_q];

    // Pattern counters train on every resolved branch, independent of BTB hit or allocation.
    always_comb begin
        pht_d = pht_q;
        ghr_d = ghr_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_d[i] = CTR_INIT;
            end
            ghr_d = '0;
        end else if (upd_valid) begin
            pht_d[upd_pht_idx] = ctr_next(pht_q[upd_pht_idx], upd_taken);
            ghr_d              = {ghr_q[IDX_W-2:0], upd_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CTR_INIT;
            end
            ghr_q <= '0;
        end else begin
            pht_q <= pht_d;
            ghr_q <= ghr_d;
        end
    end
`else
    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    assign lookup_ctr = ctr_q[lookup_idx];

    // A fresh allocation starts weakly taken since the branch was just seen taken.
    always_comb begin
        ctr_d = ctr_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_d[i] = CTR_INIT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken);
            end else if (upd_taken) begin
                ctr_d[upd_idx] = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Table-driven bench for branch_predictor_btb (default build), with a 4-bit mispredict counter
// so saturation is reachable, plus hand sequences for saturation and asynchronous reset.
module tb_branch_predictor_btb;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [31:0]      lookup_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_mispredict;
    logic             flush;
    logic [CNT_W-1:0] mispredict_cnt;

    int checks;
    int errors;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        ump;
        logic        fl;
        logic [31:0] lpc;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    branch_predictor_btb #(
        .ENTRIES (16),
        .ADDR_W  (32),
        .CTR_INIT(2'b01),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc     (lookup_pc),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispredict(upd_mispredict),
        .flush         (flush),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic ump, input logic fl,
                                input logic [31:0] lpc, input logic e_hit, input logic e_tk,
                                input logic [31:0] e_tgt, input logic [31:0] e_cnt);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.ump = ump; v.fl = fl;
        v.lpc = lpc; v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        upd_valid      = v.uv;
        upd_pc         = v.upc;
        upd_taken      = v.ut;
        upd_target     = v.utgt;
        upd_mispredict = v.ump;
        flush          = v.fl;
        lookup_pc      = v.lpc;
    endtask

    task automatic checkOutput(input string name, input int row, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s row %0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int row, input logic e_hit, input logic e_tk,
                            input logic [31:0] e_tgt, input logic [31:0] e_cnt);
        checkOutput({tag, "_hit"}, row, {31'b0, pred_hit}, {31'b0, e_hit});
        checkOutput({tag, "_taken"}, row, {31'b0, pred_taken}, {31'b0, e_tk});
        checkOutput({tag, "_target"}, row, pred_target, e_tgt);
        checkOutput({tag, "_cnt"}, row, 32'(mispredict_cnt), e_cnt);
    endtask

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] PC_B = 32'h0040_0050;
    localparam logic [31:0] PC_C = 32'h0040_0020;
    localparam logic [31:0] T1   = 32'h0040_0100;
    localparam logic [31:0] T2   = 32'h0040_0200;
    localparam logic [31:0] T3   = 32'h0040_0300;
    localparam logic [31:0] T4   = 32'h0040_0400;

    initial begin
        vec_t idle;
        checks = 0;
        errors = 0;

        // Each row: inputs applied, outputs checked before the edge that commits the update.
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_A, 0, 0, 32'h0040_0014, 0));
        vecs.push_back(mk(1, PC_A, 1, T1, 1, 0, PC_A, 0, 0, 32'h0040_0014, 0));
        vecs.push_back(mk(1, PC_A, 0, T1, 1, 0, PC_A, 1, 1, T1, 1));
        vecs.push_back(mk(1, PC_A, 0, T1, 0, 0, PC_A, 1, 0, T1, 2));
        vecs.push_back(mk(1, PC_A, 1, T1, 1, 0, PC_A, 1, 0, T1, 2));
        vecs.push_back(mk(1, PC_A, 1, T1, 0, 0, PC_A, 1, 0, T1, 3));
        vecs.push_back(mk(1, PC_A, 1, T1, 0, 0, PC_A, 1, 1, T1, 3));
        vecs.push_back(mk(1, PC_A, 1, T1, 0, 0, PC_A, 1, 1, T1, 3));
        vecs.push_back(mk(1, PC_A, 0, T1, 0, 0, PC_A, 1, 1, T1, 3));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_A, 1, 1, T1, 3));
        vecs.push_back(mk(1, PC_A, 0, T1, 0, 0, PC_A, 1, 1, T1, 3));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_A, 1, 0, T1, 3));
        vecs.push_back(mk(1, PC_A, 1, T2, 0, 0, PC_A, 1, 0, T1, 3));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_A, 1, 1, T2, 3));
        vecs.push_back(mk(1, PC_A, 0, 32'h1234_5678, 0, 0, PC_A, 1, 1, T2, 3));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_A, 1, 0, T2, 3));
        vecs.push_back(mk(1, PC_B, 0, 32'hDEAD_BEEF, 0, 0, PC_A, 1, 0, T2, 3));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_B, 0, 0, 32'h0040_0054, 3));
        vecs.push_back(mk(1, PC_B, 1, T3, 1, 0, PC_B, 0, 0, 32'h0040_0054, 3));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_A, 0, 0, 32'h0040_0014, 4));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_B, 1, 1, T3, 4));
        vecs.push_back(mk(1, PC_C, 1, T4, 0, 0, PC_C, 0, 0, 32'h0040_0024, 4));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_C, 1, 1, T4, 4));
        vecs.push_back(mk(1, PC_A, 1, T1, 1, 1, PC_B, 1, 1, T3, 4));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_A, 0, 0, 32'h0040_0014, 5));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_B, 0, 0, 32'h0040_0054, 5));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_C, 0, 0, 32'h0040_0024, 5));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, 32'hFFFF_FFFC, 0, 0, 32'h0000_0000, 5));
        vecs.push_back(mk(0, PC_A, 1, T1, 1, 0, PC_A, 0, 0, 32'h0040_0014, 5));
        vecs.push_back(mk(0, 0,    0, 0,  0, 0, PC_A, 0, 0, 32'h0040_0014, 5));

        idle = mk(0, 0, 0, 0, 0, 0, PC_A, 0, 0, 0, 0);
        applyStimulus(idle);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkAll("vec", i, vecs[i].e_hit, vecs[i].e_tk, vecs[i].e_tgt, vecs[i].e_cnt);
        end

        // Twenty qualified mispredicts on top of five already counted: 4-bit counter pins at 15.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(mk(1, PC_C, 0, 0, 1, 0, PC_A, 0, 0, 0, 0));
        end
        @(negedge clk);
        applyStimulus(idle);
        #1;
        checkOutput("cnt_saturate", 0, 32'(mispredict_cnt), 32'd15);

        // Allocate A, then assert reset asynchronously while an update to B is pending.
        @(negedge clk);
        applyStimulus(mk(1, PC_A, 1, T1, 0, 0, PC_A, 0, 0, 0, 0));
        @(negedge clk);
        applyStimulus(mk(1, PC_B, 1, T3, 1, 0, PC_A, 0, 0, 0, 0));
        #1;
        checkAll("pre_rst", 0, 1'b1, 1'b1, T1, 32'd15);
        #1;
        rst = 1'b1;
        #1;
        checkAll("async_rst", 0, 1'b0, 1'b0, 32'h0040_0014, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, PC_B, 0, 0, 0, 0));
        #1;
        checkAll("post_rst_b", 0, 1'b0, 1'b0, 32'h0040_0054, 32'd0);
        lookup_pc = PC_A;
        #1;
        checkAll("post_rst_a", 0, 1'b0, 1'b0, 32'h0040_0014, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised direct-mapped branch target buffer with per-entry 2-bit saturating direction counters, indexed by fetch PC.
- Successor to the fixed six-counter, per-opcode predictor: prediction is per branch address, not per opcode, and the target is stored rather than recomputed from the instruction.
- Sits beside fetch: combinational lookup on the fetch PC; trains from the resolve stage one update per cycle.
- Adds table flush and a misprediction statistics counter.

Parameters:
ENTRIES, 16, number of table entries; power of two, 4..256; IDX_W = log2(ENTRIES).
ADDR_W, 32, PC and target width.
CTR_INIT, 2'b01, counter value loaded at reset and flush (weakly not-taken).
CNT_W, 16, width of the mispredict statistics counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
lookup_pc  in  ADDR_W  fetch PC to predict.
pred_hit  out  1  valid entry with matching tag for lookup_pc.
pred_taken  out  1  pred_hit and counter MSB = 1.
pred_target  out  ADDR_W  stored target on hit; lookup_pc+4 otherwise.
upd_valid  in  1  resolved conditional branch this cycle.
upd_pc  in  ADDR_W  PC of the resolved branch.
upd_taken  in  1  actual outcome.
upd_target  in  ADDR_W  actual taken target.
upd_mispredict  in  1  resolve stage flagged a mispredict; qualified by upd_valid.
flush  in  1  invalidate all entries.
mispredict_cnt  out  CNT_W  saturating count of qualified mispredicts.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Per entry: valid, tag, target, ctr[1:0].
- Lookup: purely combinational, zero latency. A same-cycle update to the same index is not bypassed: lookup sees pre-edge contents.
- Reset, asynchronous:
  - all valid = 0; all ctr = CTR_INIT; mispredict_cnt = 0.
  - Outputs become pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+4.
  - Reset mid-update discards that update.
- Update on a clk edge with upd_valid = 1 and flush = 0:
  - Hit, taken: ctr+1, saturating at 11; target <= upd_target.
  - Hit, not taken: ctr-1, saturating at 00; target unchanged.
  - Miss, taken: allocate, overwriting any occupant: valid = 1, tag, target = upd_target, ctr = 2'b10.
  - Miss, not taken: no change.
- Flush has priority over a same-cycle update:
  - all valid = 0; all ctr = CTR_INIT; the update is dropped.
  - mispredict_cnt unaffected.
- mispredict_cnt:
  - Increments when upd_valid and upd_mispredict are both 1, including during a flush cycle.
  - Holds at all-ones.
- pred_target+4 wraps modulo 2^ADDR_W.
- Tag aliasing across distinct PCs with equal index evicts the old entry; there is no replacement policy.

Optional Feature:
GSHARE_EN.
- Defined:
  - Direction counters move to a separate ENTRIES-deep pattern table indexed by pc index XOR ghr.
  - ghr is an IDX_W-bit global history register.
  - On every qualified update, ghr <= {ghr[IDX_W-2:0], upd_taken}.
  - ghr resets to 0 and is cleared by flush.
  - The update uses upd_pc index XOR the pre-update ghr value.
  - pred_taken = pred_hit and pattern counter MSB.
  - Pattern counters train on every update, hit or miss; on allocation the pattern counter is not forced to 10.
  - BTB valid/tag/target behave as without the macro.
- Undefined: no ghr; per-entry counters as above.

Test Plan:
- Reset, then lookup_pc=0x00400010 -> pred_hit=0, pred_taken=0, pred_target=0x00400014, mispredict_cnt=0.
- Allocation: update pc=0x00400010, taken, target=0x00400100, then next-cycle lookup of the same PC -> hit=1, taken=1, target=0x00400100.
- Counter training: two not-taken updates on that entry (ctr 10->01->00) -> taken=0, hit=1. Then three taken updates -> ctr saturates at 11 with no wrap. One not-taken -> taken=1 (ctr 10).
- Aliasing and same-cycle update:
  - Allocate 0x00400010, then allocate 0x00400050 (same index 4, different tag) -> lookup 0x00400010 misses; 0x00400050 hits.
  - Lookup and update of the same PC in one cycle -> lookup shows the old value.
- Flush: flush=1 together with upd_valid=1, upd_mispredict=1 -> all entries miss next cycle; the update is not applied; mispredict_cnt increments by 1.
- Saturation and reset:
  - With CNT_W=4: 20 qualified mispredicts -> mispredict_cnt=15.
  - Assert rst mid-stream -> immediate zero and miss on all outputs.
  - With GSHARE_EN: ghr reads 4'b1011 after the outcome sequence T,N,T,T from reset.
